// File: rtl/clk_div_prog.sv
// Programmable clock divider.
//
// Divides clk_in by a run-time programmable period with a programmable high
// phase. The low phase comes first in each period. A new configuration is
// staged as "pending" and only takes effect at the next period boundary, so
// the output never produces a truncated or glitched period.
//
// Parameters:
//   WIDTH      - width of the counter and configuration fields
//   DEF_PERIOD - period (clk_in cycles) used out of reset
//   DEF_HIGH   - high-phase length (clk_in cycles) used out of reset
//
// Ports:
//   clk_in      - clock, all state updates on rising edge
//   reset_n     - asynchronous active-low reset
//   enable      - counting advances when high, holds when low
//   load        - single-cycle request to capture period_in/high_in
//   period_in   - requested period, sampled when load=1
//   high_in     - requested high-phase length, sampled when load=1
//   clk_out     - registered divided clock
//   tick        - registered one-cycle pulse at each period start
//   cfg_pending - an accepted configuration awaits the next wrap
//   cfg_err     - registered one-cycle pulse when a load is rejected
module clk_div_prog #(
  parameter int unsigned      WIDTH      = 26,
  parameter logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(500000),
  parameter logic [WIDTH-1:0] DEF_HIGH   = WIDTH'(250000)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);
  localparam logic [WIDTH-1:0] Two = WIDTH'(2);

  // Reset-time configuration must itself be a legal configuration.
  if (!((DEF_PERIOD >= Two) && (DEF_HIGH >= One) && (DEF_HIGH < DEF_PERIOD))) begin : g_bad_defaults
    $error("clk_div_prog: DEF_PERIOD/DEF_HIGH do not form a legal configuration");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_a_q, per_a_d;
  logic [WIDTH-1:0] high_a_q, high_a_d;
  logic [WIDTH-1:0] per_p_q, per_p_d;
  logic [WIDTH-1:0] high_p_q, high_p_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             load_ok;

  // high < period together with high >= 1 keeps per-high in [1, per-1],
  // so the low-phase threshold below cannot underflow.
  assign wrap    = (cnt_q == (per_a_q - One));
  assign load_ok = (period_in >= Two) && (high_in >= One) && (high_in < period_in);

  always_comb begin
    cnt_d    = cnt_q;
    per_a_d  = per_a_q;
    high_a_d = high_a_q;
    per_p_d  = per_p_q;
    high_p_d = high_p_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    err_d    = 1'b0;

    if (enable) begin
      cnt_d  = wrap ? '0 : (cnt_q + One);
      tick_d = wrap;
      // Apply the old pending config before a coincident load restages it.
      if (wrap && pend_q) begin
        per_a_d  = per_p_q;
        high_a_d = high_p_q;
        pend_d   = 1'b0;
      end
    end

    // Loads are serviced regardless of enable.
    if (load) begin
      if (load_ok) begin
        per_p_d  = period_in;
        high_p_d = high_in;
        pend_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Computed from next-state values so the registered output matches the
    // counter and active configuration in the same cycle.
    clk_out_d = (cnt_d >= (per_a_d - high_a_d));
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      per_a_q   <= DEF_PERIOD;
      high_a_q  <= DEF_HIGH;
      per_p_q   <= DEF_PERIOD;
      high_p_q  <= DEF_HIGH;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_a_q   <= per_a_d;
      high_a_q  <= high_a_d;
      per_p_q   <= per_p_d;
      high_p_q  <= high_p_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;

endmodule
